// File: rtl/conv_pkg.sv
// Shared defaults and small helpers for the line-convolution datapath.
package conv_pkg;

  localparam int ACT_W_DEF   = 8;
  localparam int WGT_W_DEF   = 8;
  localparam int INTER_W_DEF = 20;
  localparam int KSIZE_DEF   = 3;

  // Counter width that stays legal for a single-entry bank.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_tap.sv
// One convolution tap: signed multiply, product register, then masked
// sign-extension into the output register that holds between samples.
module conv_tap
  import conv_pkg::*;
#(
  parameter int ACT_W     = ACT_W_DEF,
  parameter int WGT_W     = WGT_W_DEF,
  parameter int INTER_W   = INTER_W_DEF,
  parameter bit IS_CENTER = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [ACT_W-1:0]   act_data,
  input  logic                      act_valid,
  input  logic                      s1_valid,
  input  logic                      s1_mode,
  input  logic signed [WGT_W-1:0]   weight,
  output logic signed [INTER_W-1:0] inter_tap
);

  localparam int PROD_W = ACT_W + WGT_W;

  logic signed [PROD_W-1:0]  prod_next;
  logic signed [PROD_W-1:0]  prod_reg;
  logic signed [INTER_W-1:0] tap_next;
  logic signed [INTER_W-1:0] tap_reg;

  always_comb begin
    prod_next = PROD_W'(act_data) * PROD_W'(weight);
    // 1x1 mode keeps only the centre tap alive.
    tap_next  = (s1_mode && !IS_CENTER) ? '0 : INTER_W'(prod_reg);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_reg <= '0;
      tap_reg  <= '0;
    end else begin
      if (act_valid) prod_reg <= prod_next;
      if (s1_valid)  tap_reg  <= tap_next;
    end
  end

  assign inter_tap = tap_reg;

endmodule

// File: rtl/conv_line_param.sv
// Parameterised 1-D convolution line: double-buffered serial weight load
// feeding KSIZE two-stage multiply taps.
module conv_line_param
  import conv_pkg::*;
#(
  parameter int ACT_W   = ACT_W_DEF,
  parameter int WGT_W   = WGT_W_DEF,
  parameter int INTER_W = INTER_W_DEF,
  parameter int KSIZE   = KSIZE_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ACT_W-1:0]         act_data,
  input  logic                     act_valid,
  input  logic                     mode_1_1,
  input  logic [WGT_W-1:0]         weight_data,
  input  logic                     weight_valid,
  input  logic                     weight_switch,
  output logic [KSIZE*INTER_W-1:0] inter_data,
  output logic                     inter_valid,
  output logic                     weight_ready,
  output logic                     load_err
);

  localparam int CNT_W  = cnt_width(KSIZE);
  localparam int CENTER = KSIZE / 2;

  if (INTER_W < ACT_W + WGT_W || KSIZE % 2 == 0 || KSIZE < 1 || KSIZE > 7) begin : g_param_check
    $error("conv_line_param: INTER_W too narrow or KSIZE not odd in 1..7");
  end

  logic signed [WGT_W-1:0] shadow_reg [KSIZE];
  logic signed [WGT_W-1:0] active_reg [KSIZE];
  logic signed [WGT_W-1:0] shadow_sel [KSIZE];
  logic                    tap_wr     [KSIZE];

  logic [CNT_W-1:0] wcnt_reg, wcnt_next;
  logic             weight_ready_reg, weight_ready_next;
  logic             load_err_reg, load_err_next;
  logic             s1_valid_reg, s1_mode_reg, s2_valid_reg;

  logic write_en, last_write, ready_after, switch_ok;

  always_comb begin
    write_en    = weight_valid && !weight_ready_reg;
    last_write  = write_en && (wcnt_reg == CNT_W'(KSIZE - 1));
    // A switch in the same cycle as the final word sees the completed bank.
    ready_after = weight_ready_reg || last_write;
    switch_ok   = weight_switch && ready_after;

    wcnt_next = wcnt_reg;
    if (last_write)    wcnt_next = '0;
    else if (write_en) wcnt_next = wcnt_reg + CNT_W'(1);

    weight_ready_next = switch_ok ? 1'b0 : ready_after;
    load_err_next     = load_err_reg
                      | (weight_valid && weight_ready_reg)
                      | (weight_switch && !ready_after);
  end

  for (genvar gi = 0; gi < KSIZE; gi++) begin : g_bank
    assign tap_wr[gi]     = write_en && (wcnt_reg == CNT_W'(gi));
    assign shadow_sel[gi] = tap_wr[gi] ? WGT_W'(weight_data) : shadow_reg[gi];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < KSIZE; i++) begin
        shadow_reg[i] <= '0;
        active_reg[i] <= '0;
      end
      wcnt_reg         <= '0;
      weight_ready_reg <= 1'b0;
      load_err_reg     <= 1'b0;
      s1_valid_reg     <= 1'b0;
      s1_mode_reg      <= 1'b0;
      s2_valid_reg     <= 1'b0;
    end else begin
      for (int i = 0; i < KSIZE; i++) begin
        shadow_reg[i] <= shadow_sel[i];
        if (switch_ok) active_reg[i] <= shadow_sel[i];
      end
      wcnt_reg         <= wcnt_next;
      weight_ready_reg <= weight_ready_next;
      load_err_reg     <= load_err_next;
      s1_valid_reg     <= act_valid;
      if (act_valid) s1_mode_reg <= mode_1_1;
      s2_valid_reg     <= s1_valid_reg;
    end
  end

  for (genvar gi = 0; gi < KSIZE; gi++) begin : g_tap
    conv_tap #(
      .ACT_W     (ACT_W),
      .WGT_W     (WGT_W),
      .INTER_W   (INTER_W),
      .IS_CENTER (gi == CENTER)
    ) u_tap (
      .clk       (clk),
      .rst       (rst),
      .act_data  (ACT_W'(act_data)),
      .act_valid (act_valid),
      .s1_valid  (s1_valid_reg),
      .s1_mode   (s1_mode_reg),
      .weight    (active_reg[gi]),
      .inter_tap (inter_data[gi*INTER_W +: INTER_W])
    );
  end

  assign inter_valid  = s2_valid_reg;
  assign weight_ready = weight_ready_reg;
  assign load_err     = load_err_reg;

endmodule

// File: tb/tb_conv_line_param.sv
// Directed bench for conv_line_param: stimulus pushes expected tap vectors
// with their due cycle; a negedge monitor pops and checks them.
module tb_conv_line_param;
  import conv_pkg::*;

  localparam int AW = ACT_W_DEF;
  localparam int WW = WGT_W_DEF;
  localparam int IW = INTER_W_DEF;
  localparam int KS = KSIZE_DEF;
  localparam int DW = KS * IW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] act_data = '0;
  logic          act_valid = 1'b0;
  logic          mode_1_1 = 1'b0;
  logic [WW-1:0] weight_data = '0;
  logic          weight_valid = 1'b0;
  logic          weight_switch = 1'b0;
  logic [DW-1:0] inter_data;
  logic          inter_valid;
  logic          weight_ready;
  logic          load_err;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          sb[$];
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] last_data = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv_line_param dut (
    .clk           (clk),
    .rst           (rst),
    .act_data      (act_data),
    .act_valid     (act_valid),
    .mode_1_1      (mode_1_1),
    .weight_data   (weight_data),
    .weight_valid  (weight_valid),
    .weight_switch (weight_switch),
    .inter_data    (inter_data),
    .inter_valid   (inter_valid),
    .weight_ready  (weight_ready),
    .load_err      (load_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: independent per-tap product, truncated to IW bits two's complement.
  function automatic logic [DW-1:0] pack_exp(input int a, input int w0, input int w1,
                                             input int w2, input bit m);
    logic [DW-1:0] r;
    int w[3];
    int p;
    w = '{w0, w1, w2};
    r = '0;
    for (int k = 0; k < 3; k++) begin
      p = a * w[k];
      if (m && k != 1) p = 0;
      r[k*IW +: IW] = p[IW-1:0];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic load_w(input int v);
    weight_valid = 1'b1;
    weight_data  = WW'(v);
    tick();
    weight_valid = 1'b0;
  endtask

  task automatic sw();
    weight_switch = 1'b1;
    tick();
    weight_switch = 1'b0;
  endtask

  task automatic push_exp(input logic [DW-1:0] d);
    exp_t e;
    e.data = d;
    e.due  = cyc + 2;
    sb.push_back(e);
  endtask

  task automatic send_act(input int a, input bit m, input logic [DW-1:0] e);
    act_valid = 1'b1;
    act_data  = AW'(a);
    mode_1_1  = m;
    push_exp(e);
    tick();
    act_valid = 1'b0;
    mode_1_1  = 1'b0;
  endtask

  task automatic do_reset();
    idle(4);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Output monitor: valid must appear exactly on the due cycle, data holds otherwise.
  always @(negedge clk) begin
    if (rst) begin
      last_data = '0;
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      chk("valid_on_due", {63'd0, inter_valid}, 64'd1);
      chk("due_cycle", 64'(sb[0].due), 64'(cyc));
      chk("inter_data", 64'(inter_data), 64'(sb[0].data));
      $display("txn cyc=%0d data=%h exp=%h", cyc, inter_data, sb[0].data);
      last_data = sb[0].data;
      void'(sb.pop_front());
    end else begin
      chk("valid_idle", {63'd0, inter_valid}, 64'd0);
      chk("data_hold", 64'(inter_data), 64'(last_data));
    end
  end

  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk("rst_ready", {63'd0, weight_ready}, 64'd0);
    chk("rst_err", {63'd0, load_err}, 64'd0);
    chk("rst_data", 64'(inter_data), 64'd0);

    // No switch yet: active bank is zero.
    send_act(7, 1'b0, pack_exp(7, 0, 0, 0, 1'b0));

    load_w(1); load_w(2);
    chk("ready_partial", {63'd0, weight_ready}, 64'd0);
    load_w(3);
    chk("ready_full", {63'd0, weight_ready}, 64'd1);
    sw();
    chk("ready_after_sw", {63'd0, weight_ready}, 64'd0);
    chk("err_clean", {63'd0, load_err}, 64'd0);
    send_act(5, 1'b0, pack_exp(5, 1, 2, 3, 1'b0));
    idle(3);
    send_act(5, 1'b1, pack_exp(5, 1, 2, 3, 1'b1));
    send_act(3, 1'b0, pack_exp(3, 1, 2, 3, 1'b0));
    send_act(-4, 1'b0, pack_exp(-4, 1, 2, 3, 1'b0));
    idle(3);

    load_w(-1); load_w(127); load_w(-128);
    sw();
    send_act(-128, 1'b0, pack_exp(-128, -1, 127, -128, 1'b0));

    // Premature switch: error, old weights stay active.
    do_reset();
    load_w(1); load_w(2); load_w(3);
    sw();
    load_w(4); load_w(5);
    sw();
    chk("err_early_sw", {63'd0, load_err}, 64'd1);
    chk("ready_early_sw", {63'd0, weight_ready}, 64'd0);
    send_act(1, 1'b0, pack_exp(1, 1, 2, 3, 1'b0));

    // Extra weight after bank full: error, shadow untouched.
    do_reset();
    load_w(4); load_w(5); load_w(6);
    chk("err_before_extra", {63'd0, load_err}, 64'd0);
    load_w(99);
    chk("err_extra_w", {63'd0, load_err}, 64'd1);
    chk("ready_extra_w", {63'd0, weight_ready}, 64'd1);
    sw();
    send_act(1, 1'b0, pack_exp(1, 4, 5, 6, 1'b0));

    // Final word, switch and sample in the same cycle.
    do_reset();
    load_w(1); load_w(2); load_w(3);
    sw();
    load_w(7); load_w(8);
    weight_valid  = 1'b1;
    weight_data   = WW'(9);
    weight_switch = 1'b1;
    send_act(2, 1'b0, pack_exp(2, 1, 2, 3, 1'b0));
    weight_valid  = 1'b0;
    weight_switch = 1'b0;
    send_act(2, 1'b0, pack_exp(2, 7, 8, 9, 1'b0));
    chk("ready_coincide", {63'd0, weight_ready}, 64'd0);
    chk("err_coincide", {63'd0, load_err}, 64'd0);

    // Reset mid-load discards everything.
    idle(3);
    load_w(1); load_w(2);
    do_reset();
    send_act(9, 1'b0, pack_exp(9, 0, 0, 0, 1'b0));
    chk("err_after_rst", {63'd0, load_err}, 64'd0);
    chk("ready_after_rst", {63'd0, weight_ready}, 64'd0);
    load_w(1); load_w(1); load_w(1);
    chk("ready_reload", {63'd0, weight_ready}, 64'd1);
    sw();
    send_act(9, 1'b0, pack_exp(9, 1, 1, 1, 1'b0));

    for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/conv_line_param.md
CONV_LINE_PARAM -- requirements
Module: conv_line_param

Interface
REQ-001 SHALL have parameter ACT_W, default 8, activation width (signed).
REQ-002 SHALL have parameter WGT_W, default 8, weight width (signed).
REQ-003 SHALL have parameter INTER_W, default 20, per-tap product width (signed).
REQ-004 SHALL have parameter KSIZE, default 3, tap count; odd, 1..7.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port act_data  input  ACT_W  activation sample.
REQ-008 SHALL have port act_valid  input  1  act_data qualifier.
REQ-009 SHALL have port mode_1_1  input  1  1x1-kernel mode, sampled with act_valid.
REQ-010 SHALL have port weight_data  input  WGT_W  serial weight word.
REQ-011 SHALL have port weight_valid  input  1  weight_data qualifier; tap 0 first.
REQ-012 SHALL have port weight_switch  input  1  one-cycle pulse; promote shadow weights to active.
REQ-013 SHALL have port inter_data  output  KSIZE*INTER_W  packed tap products; tap k at bits [k*INTER_W +: INTER_W].
REQ-014 SHALL have port inter_valid  output  1  inter_data qualifier.
REQ-015 SHALL have port weight_ready  output  1  shadow bank holds KSIZE loaded weights.
REQ-016 SHALL have port load_err  output  1  sticky protocol-error flag.

Function
REQ-017 SHALL hold two weight banks (shadow, active), each KSIZE x WGT_W.
REQ-018 SHALL, on weight_valid with weight_ready=0, write shadow[wcnt] and increment wcnt; on the write to tap KSIZE-1, reset wcnt to 0 and set weight_ready.
REQ-019 SHALL, on weight_valid with weight_ready=1, leave the shadow bank unchanged and set load_err.
REQ-020 SHALL, on weight_switch with weight_ready=1, copy shadow to active and clear weight_ready; wcnt stays 0.
REQ-021 SHALL, on weight_switch with weight_ready=0, leave all weights and wcnt unchanged and set load_err.
REQ-022 SHALL, when the final weight_valid and weight_switch coincide, complete the write and promote the bank that includes the new word in the same cycle; weight_ready ends at 0.
REQ-023 SHALL use the active bank as it was before the clock edge for an act_valid sample; a sample coincident with weight_switch uses the old weights.
REQ-024 SHALL, in stage 1, register the full-precision signed product act_data*active[k] for each tap, together with act_valid and mode_1_1.
REQ-025 SHALL, in stage 2, sign-extend each product to INTER_W, force every tap except k=KSIZE/2 to zero when the staged mode_1_1=1, and register the result.
REQ-026 SHALL assert inter_valid exactly 2 cycles after act_valid, for one cycle per sample, at full throughput (back-to-back samples allowed).
REQ-027 SHALL hold inter_data at its last value while inter_valid=0.
REQ-028 SHALL fail elaboration if INTER_W < ACT_W+WGT_W or KSIZE is even.

Reset
REQ-029 SHALL, while rst=1 at a clock edge, clear both banks, wcnt, weight_ready, load_err, the pipeline valids, and inter_data to 0.
REQ-030 SHALL discard any partial weight load or in-flight samples on rst; samples arriving after reset produce products of 0 until a switch occurs.
REQ-031 SHALL keep load_err set until rst.

Structure
REQ-032 SHALL place default widths (ACT_W, WGT_W, INTER_W, KSIZE) in the shared package conv_pkg.
REQ-033 SHALL implement one tap as sub-module conv_tap (multiply, stage-1/stage-2 registers, masking) instantiated KSIZE times by generate.
REQ-034 SHALL keep weight-load control (wcnt, weight_ready, load_err, banks) in the top module.

Verification
REQ-035 SHALL cover: load 1,2,3; switch; act 5 -> 2 cycles later inter_data taps {5,10,15} with inter_valid high for 1 cycle.
REQ-036 SHALL cover: same weights, mode_1_1=1, act 5 -> taps {0,10,0}.
REQ-037 SHALL cover: weights -1,127,-128; act -128 -> taps {128,-16256,16384}, sign-extended to 20 bits.
REQ-038 SHALL cover: switch after 2 weights -> load_err=1 and the old weights still apply; a 4th weight_valid after weight_ready=1 -> load_err=1 and the shadow is unchanged.
REQ-039 SHALL cover: last weight and switch in the same cycle with act 2 also valid -> that sample uses the old weights; the next sample uses the new weights; weight_ready=0.
REQ-040 SHALL cover: rst after 2 of 3 weights, then act 9 -> taps {0,0,0}, load_err=0, weight_ready=0; a full reload then works normally.
